// File: rtl/note_player_pkg.sv
// Shared widths and FSM state encoding for the note sample player.
package note_player_pkg;

  localparam int unsigned STEP_W    = 20;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned DUR_W     = 6;
  localparam int unsigned TIMEOUT_W = 5;
  localparam int unsigned GAIN_W    = 5;
  localparam int unsigned GAIN_MAX  = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/note_duration_counter.sv
// Loadable beat-driven down-counter that saturates at zero and flags it.
module note_duration_counter #(
  parameter int unsigned DUR_W = note_player_pkg::DUR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [DUR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [DUR_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/note_sample_player.sv
// Plays one note: requests a generator sample per codec tick until the beats run out.
// Optional attack ramp on the output sample: NOTE_SAMPLE_PLAYER_ATTACK_EN.
module note_sample_player #(
  parameter int unsigned STEP_W         = note_player_pkg::STEP_W,
  parameter int unsigned SAMPLE_W       = note_player_pkg::SAMPLE_W,
  parameter int unsigned DUR_W          = note_player_pkg::DUR_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                play_enable,
  input  logic                load_new_note,
  input  logic [STEP_W-1:0]   step_size_in,
  input  logic [DUR_W-1:0]    duration_in,
  input  logic                beat,
  input  logic                new_sample_request,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [STEP_W-1:0]   step_size,
  output logic                generate_next_sample,
  output logic                note_done,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                overrun,
  output logic                busy
);

  import note_player_pkg::*;

  state_t                 r_state;
  state_t                 w_next;
  logic [TIMEOUT_W-1:0]   r_to;
  logic [TIMEOUT_W-1:0]   w_to_next;
  logic                   w_load;
  logic                   w_accept;
  logic                   w_timeout;
  logic                   w_dec;
  logic                   w_zero;
  logic                   w_active;
  logic [SAMPLE_W-1:0]    w_sample;

  note_duration_counter #(.DUR_W(DUR_W)) u_dur (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (duration_in),
    .i_dec      (w_dec),
    .o_zero_c   (w_zero)
  );

  // State and request-timeout registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_to    <= '0;
    end else begin
      r_state <= w_next;
      r_to    <= w_to_next;
    end
  end

  // Next state; a sample exchange in flight always finishes before DONE.
  always_comb begin
    w_next    = r_state;
    w_to_next = r_to;
    w_load    = 1'b0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_new_note) begin
          w_load = 1'b1;
          w_next = (duration_in == '0) ? S_DONE : S_PLAY;
        end
      end
      S_PLAY: begin
        if (play_enable && new_sample_request) begin
          w_next = S_REQ;
        end else if (w_zero) begin
          w_next = S_DONE;
        end
      end
      S_REQ: begin
        w_to_next = '0;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (sample_ready) begin
          w_accept = 1'b1;
        end else if (r_to == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout = 1'b1;
        end else begin
          w_to_next = r_to + 1'b1;
        end
        if (w_accept || w_timeout) begin
          w_next = w_zero ? S_DONE : S_PLAY;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_active = (r_state == S_PLAY) || (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_dec    = w_active && beat && play_enable;

`ifdef NOTE_SAMPLE_PLAYER_ATTACK_EN
  logic [GAIN_W-1:0]            r_gain;
  logic signed [SAMPLE_W+5:0]   w_prod;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gain <= '0;
    end else if (w_load) begin
      r_gain <= '0;
    end else if (w_accept && (r_gain < GAIN_W'(GAIN_MAX))) begin
      r_gain <= r_gain + 1'b1;
    end
  end

  assign w_prod   = $signed(sample_in) * $signed({1'b0, r_gain});
  assign w_sample = SAMPLE_W'(w_prod >>> 4);
`else
  assign w_sample = sample_in;
`endif

  // Registered outputs, all derived from the upcoming state or this cycle's events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_size            <= '0;
      generate_next_sample <= 1'b0;
      note_done            <= 1'b1;
      sample_out           <= '0;
      sample_valid         <= 1'b0;
      overrun              <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      generate_next_sample <= (w_next == S_REQ);
      note_done            <= (w_next == S_IDLE) || (w_next == S_DONE);
      busy                 <= (w_next != S_IDLE);
      sample_valid         <= w_accept || w_timeout;
      overrun              <= new_sample_request &&
                              ((r_state == S_REQ) || (r_state == S_WAIT));
      if (w_load) begin
        step_size <= step_size_in;
      end
      if (w_accept) begin
        sample_out <= w_sample;
      end else if (w_timeout) begin
        sample_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_note_sample_player.sv
// Scoreboard bench for note_sample_player; honours NOTE_SAMPLE_PLAYER_ATTACK_EN.
module tb_note_sample_player;

  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play_enable = 1'b0;
  logic        load_new_note = 1'b0;
  logic [19:0] step_size_in = '0;
  logic [5:0]  duration_in = '0;
  logic        beat = 1'b0;
  logic        new_sample_request = 1'b0;
  logic        sample_ready = 1'b0;
  logic [15:0] sample_in = '0;
  logic [19:0] step_size;
  logic        generate_next_sample;
  logic        note_done;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        overrun;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_gen = 0;
  int          m_gain = 0;
  int          g0;
  logic [15:0] sb_q[$];

  note_sample_player #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .step_size_in         (step_size_in),
    .duration_in          (duration_in),
    .beat                 (beat),
    .new_sample_request   (new_sample_request),
    .sample_ready         (sample_ready),
    .sample_in            (sample_in),
    .step_size            (step_size),
    .generate_next_sample (generate_next_sample),
    .note_done            (note_done),
    .sample_out           (sample_out),
    .sample_valid         (sample_valid),
    .overrun              (overrun),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every sample_valid.
  always @(negedge clk) begin
    if (generate_next_sample) n_gen++;
    if (sample_valid) begin
      if (sb_q.size() == 0) check("unexpected_valid", 32'(sample_out), 32'hdead);
      else check("sample_out", 32'(sample_out), 32'(sb_q.pop_front()));
    end
  end

  function automatic logic [15:0] model_sample(input logic [15:0] s);
`ifdef NOTE_SAMPLE_PLAYER_ATTACK_EN
    int p;
    p = int'($signed(s)) * m_gain;
    if (m_gain < 16) m_gain++;
    return 16'(p >>> 4);
`else
    return s;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_note(input logic [19:0] st, input logic [5:0] dur);
    load_new_note = 1'b1;
    step_size_in  = st;
    duration_in   = dur;
    m_gain        = 0;
    step();
    load_new_note = 1'b0;
  endtask

  task automatic tick();
    new_sample_request = 1'b1;
    step();
    new_sample_request = 1'b0;
  endtask

  task automatic wait_gen();
    int k = 0;
    while (!generate_next_sample && k < 8) begin
      step();
      k++;
    end
    if (!generate_next_sample) check("gen_seen", 32'd0, 32'd1);
  endtask

  task automatic respond(input logic [15:0] s);
    sample_ready = 1'b1;
    sample_in    = s;
    sb_q.push_back(model_sample(s));
    step();
    sample_ready = 1'b0;
  endtask

  task automatic finish_note();
    beat = 1'b1;
    step();
    beat = 1'b0;
    repeat (3) step();
    check("finish_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    check("rst_note_done", 32'(note_done), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gen", 32'(generate_next_sample), 32'd0);
    check("rst_outs", {12'd0, step_size, sample_out[15:12]}, 32'd0);
    reset_n = 1'b1;
    play_enable = 1'b1;
    step();

    // Basic note: load, tick, response three cycles later
    load_note(20'h00400, 6'd2);
    check("step_size", 32'(step_size), 32'h00400);
    check("play_note_done", 32'(note_done), 32'd0);
    g0 = n_gen;
    tick();
    check("gen_latency", 32'(generate_next_sample), 32'd1);
    step();
    check("gen_one_cycle", 32'(generate_next_sample), 32'd0);
    step();
    step();
    respond(16'h1234);
    check("valid_latency", 32'(sample_valid), 32'd1);
    step();
    check("valid_pulse", 32'(sample_valid), 32'd0);
    check("one_request", 32'(n_gen - g0), 32'd1);

    // Two beats in PLAY -> one DONE cycle then IDLE
    beat = 1'b1;
    step();
    step();
    beat = 1'b0;
    check("pre_done", 32'(note_done), 32'd0);
    step();
    check("done_note_done", 32'(note_done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_note_done", 32'(note_done), 32'd1);

    // Last beat lands in WAIT; the pending sample still completes first
    load_note(20'h00800, 6'd1);
    g0 = n_gen;
    tick();
    step();
    beat = 1'b1;
    step();
    beat = 1'b0;
    repeat (4) step();
    check("wait_note_done", 32'(note_done), 32'd0);
    respond(16'h0abc);
    check("wait_valid", 32'(sample_valid), 32'd1);
    check("wait_then_done", 32'(note_done), 32'd1);
    check("wait_requests", 32'(n_gen - g0), 32'd1);
    step();
    check("wait_idle", 32'(busy), 32'd0);

    // Load outside IDLE ignored; tick in WAIT overruns
    load_note(20'h00100, 6'd1);
    load_new_note = 1'b1;
    step_size_in  = 20'habcde;
    step();
    load_new_note = 1'b0;
    check("load_ignored", 32'(step_size), 32'h00100);
    g0 = n_gen;
    tick();
    step();
    tick();
    check("overrun", 32'(overrun), 32'd1);
    step();
    check("overrun_pulse", 32'(overrun), 32'd0);
    respond(16'h8001);
    step();
    check("overrun_no_req", 32'(n_gen - g0), 32'd1);
    finish_note();

    // Timeout: no sample_ready
    load_note(20'h00200, 6'd1);
    tick();
    wait_gen();
    sb_q.push_back(16'h0000);
    begin
      int k = 0;
      while (!sample_valid && k < 40) begin
        step();
        k++;
      end
      check("timeout_latency", 32'(k), 32'(TIMEOUT_CYCLES + 1));
    end
    step();
    check("timeout_back_play", {31'd0, busy & ~note_done}, 32'd1);
    finish_note();

    // Pause: ticks ignored, count frozen
    load_note(20'h00300, 6'd1);
    play_enable = 1'b0;
    g0 = n_gen;
    tick();
    beat = 1'b1;
    step();
    beat = 1'b0;
    repeat (3) step();
    check("pause_no_req", 32'(n_gen - g0), 32'd0);
    check("pause_frozen", 32'(busy), 32'd1);
    play_enable = 1'b1;
    finish_note();

    // Zero duration
    g0 = n_gen;
    load_note(20'h00500, 6'd0);
    check("dur0_done", {30'd0, note_done, busy}, 32'd3);
    step();
    check("dur0_idle", 32'(busy), 32'd0);
    check("dur0_no_req", 32'(n_gen - g0), 32'd0);

    // Sample sequence (attack ramp when enabled)
    load_note(20'h01000, 6'd1);
    for (int i = 0; i < 18; i++) begin
      tick();
      wait_gen();
      step();
`ifdef NOTE_SAMPLE_PLAYER_ATTACK_EN
      respond(16'h1000);
`else
      respond(16'($urandom));
`endif
      step();
    end
    finish_note();

    // Asynchronous reset in WAIT
    load_note(20'h00700, 6'd3);
    tick();
    step();
    #2 reset_n = 1'b0;
    #1;
    check("arst_note_done", 32'(note_done), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_outs", {12'd0, step_size}, 32'd0);
    check("arst_sample", {16'd0, sample_out}, 32'd0);
    step();
    reset_n = 1'b1;
    repeat (TIMEOUT_CYCLES + 4) step();
    check("arst_stay_idle", 32'(busy), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/note_sample_player.md
Name: note_sample_player

Overview:
- Requester end of the generate_next_sample / sample_ready handshake used by the harmonic sample generators.
- Accepts one note (step size plus duration in beats) from the song sequencer.
- On each codec sample tick, issues a one-cycle generate_next_sample request and waits for sample_ready. It then registers the returned sample toward the codec and raises note_done when the duration expires.
- Sits between the song sequencer/note loader and the harmonic block; it sources the note_done and step_size signals that block consumes.

Parameters:
- STEP_W, 20, width of phase step size
- SAMPLE_W, 16, signed sample width
- DUR_W, 6, note duration width in beats
- TIMEOUT_CYCLES, 16, max clk cycles to wait for sample_ready after a request

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- play_enable  in  1  global play/pause; low freezes the duration count and blocks new requests
- load_new_note  in  1  one-cycle pulse; latch step_size_in/duration_in
- step_size_in  in  STEP_W  note step size
- duration_in  in  DUR_W  note length in beats
- beat  in  1  one-cycle beat pulse
- new_sample_request  in  1  one-cycle codec sample tick
- sample_ready  in  1  generator response, held high ≥1 cycle
- sample_in  in  SAMPLE_W  signed generator sample
- step_size  out  STEP_W  latched step size to generator
- generate_next_sample  out  1  one-cycle request pulse
- note_done  out  1  high while the note is not playing: IDLE and DONE (pulse phase)
- sample_out  out  SAMPLE_W  registered signed sample to codec
- sample_valid  out  1  one-cycle pulse when sample_out updates
- overrun  out  1  one-cycle pulse when a tick is dropped
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; all outputs 0 except note_done=1.
  - Counters and gain cleared.
  - Mid-note reset aborts immediately, with no sample_valid and no done pulse.
- States: IDLE, PLAY, REQ, WAIT, DONE.
- IDLE:
  - On load_new_note: latch step_size_in into step_size and duration_in into a remaining-beats counter.
  - If duration_in==0, go to DONE; otherwise go to PLAY.
  - All other inputs are ignored.
- PLAY:
  - If play_enable && new_sample_request, go to REQ.
  - Else if the remaining count is 0, go to DONE.
- REQ:
  - generate_next_sample=1 for exactly this one cycle.
  - Clear the timeout counter; next state WAIT.
- WAIT:
  - On sample_ready, register sample_out (see arithmetic); sample_valid=1 next cycle.
  - Then go to DONE if the remaining count is 0, else PLAY.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without sample_ready: sample_out=0, sample_valid pulse, same next-state rule.
- DONE:
  - One cycle, then IDLE.
  - note_done stays 1 through DONE and IDLE, and is 0 in PLAY/REQ/WAIT.
- Beat counting:
  - In PLAY/REQ/WAIT, beat && play_enable && remaining>0 decrements remaining.
  - It saturates at 0.
  - An in-flight request always completes before DONE.
- Overrun:
  - new_sample_request arriving in REQ or WAIT is dropped, and overrun pulses the next cycle.
  - A tick on the same cycle WAIT exits is also dropped.
- load_new_note outside IDLE is ignored; step_size holds its value.
- play_enable low in PLAY: no requests and the count is frozen. An outstanding REQ/WAIT still completes.
- sample_out holds its last value between updates.
- Latency:
  - Tick to generate_next_sample: 1 cycle.
  - sample_ready to sample_valid/sample_out: 1 cycle.

Optional Feature:
- Macro: NOTE_SAMPLE_PLAYER_ATTACK_EN.
- Defined:
  - A 5-bit gain resets to 0 on each load.
  - It increments by 1 per accepted sample and saturates at 16.
  - sample_out = (sample_in * gain) >>> 4, computed at full width and truncated to SAMPLE_W.
  - Latency is unchanged.
- Undefined: sample_out = sample_in; no gain register.

Decomposition:
- Package note_player_pkg holds:
  - state enum (IDLE=0, PLAY=1, REQ=2, WAIT=3, DONE=4), 3-bit
  - default width constants STEP_W, SAMPLE_W, DUR_W
  - timeout width constant
- Sub-module note_duration_counter: loadable, saturating, beat-enabled down-counter with a zero flag.

Test Plan:
- Load step=0x00400 with dur=2, then tick → generate_next_sample pulses 1 cycle later, step_size=0x00400. Respond with sample_ready and sample_in=16'sh1234 after 3 cycles → sample_out=0x1234 and a sample_valid pulse one cycle later.
- Two beats during PLAY → exactly one DONE cycle, then IDLE. note_done is 0 while playing and 1 from DONE on.
- Second beat arrives while in WAIT; sample_ready follows 5 cycles later → sample_valid precedes DONE and no request is lost.
- Tick issued during WAIT → overrun pulse, no second generate_next_sample.
- No sample_ready response → sample_valid with sample_out=0 at TIMEOUT_CYCLES=16, then back to PLAY. duration_in=0 → DONE immediately with no requests.
- reset_n low mid-WAIT → all outputs 0 and note_done=1 asynchronously. With ATTACK_EN and sample_in=16'sh1000 constant, sample_out ramps 0x0000, 0x0100 … saturating at 0x1000.
